// File: rtl/fragment_writer.sv
// rtl/fragment_writer.sv - converts shaded fragments into address/data pairs for the write FIFO
module fragment_writer #(
    parameter int          COORD_W     = 12,
    parameter logic [23:0] ZBUF_OFFSET = 24'h200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] fb_width,
    input  logic [COORD_W-1:0] fb_height,
    input  logic               frag_valid,
    output logic               frag_ready,
    input  logic [COORD_W-1:0] frag_x,
    input  logic [COORD_W-1:0] frag_y,
    input  logic [31:0]        frag_rgba,
    input  logic [31:0]        frag_z,
    input  logic               frag_z_en,
    input  logic               frag_last,
    output logic               FF_write,
    input  logic               FF_full,
    output logic [31:0]        FF_data,
    output logic [31:0]        pair_count,
    output logic [31:0]        byte_count,
    output logic [15:0]        drop_count,
    output logic               done
);

    // Wide enough for the byte-scaled linear index and for the 24-bit offset field.
    localparam int PW = 2 * COORD_W;
    localparam int LW = (PW + 2 > 24) ? PW + 2 : 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_CALC,
        S_PUSH_CADDR,
        S_PUSH_CDATA,
        S_PUSH_ZADDR,
        S_PUSH_ZDATA,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] width_q, width_d;
    logic [COORD_W-1:0] height_q, height_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [31:0]        rgba_q, rgba_d;
    logic [31:0]        z_q, z_d;
    logic               zen_q, zen_d;
    logic               last_q, last_d;
    logic [23:0]        off_q, off_d;
    logic [31:0]        pair_q, pair_d;
    logic [31:0]        byte_q, byte_d;
    logic [15:0]        drop_q, drop_d;

    logic [PW-1:0]      y_ext, w_ext, x_ext, lin_idx;
    logic [LW-1:0]      byte_lin;
    logic [23:0]        off_calc;
    logic [23:0]        zoff;
    logic               in_range;
    state_t             frag_end_state;

    // Linear pixel index in 2*COORD_W bits, scaled to bytes and cut to the 24-bit offset field.
    always_comb begin
        y_ext    = {{COORD_W{1'b0}}, y_q};
        w_ext    = {{COORD_W{1'b0}}, width_q};
        x_ext    = {{COORD_W{1'b0}}, x_q};
        lin_idx  = y_ext * w_ext + x_ext;
        byte_lin = LW'(lin_idx) << 2;
        off_calc = byte_lin[23:0];
        zoff     = ZBUF_OFFSET + off_q;
        in_range = (x_q < width_q) && (y_q < height_q);
        frag_end_state = last_q ? S_DONE : S_ACCEPT;
    end

    // State and datapath registers; reset abandons any partially pushed fragment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            width_q  <= '0;
            height_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rgba_q   <= '0;
            z_q      <= '0;
            zen_q    <= 1'b0;
            last_q   <= 1'b0;
            off_q    <= '0;
            pair_q   <= '0;
            byte_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rgba_q   <= rgba_d;
            z_q      <= z_d;
            zen_q    <= zen_d;
            last_q   <= last_d;
            off_q    <= off_d;
            pair_q   <= pair_d;
            byte_q   <= byte_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state and output decode; push states only advance on a write the FIFO can take.
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        x_d        = x_q;
        y_d        = y_q;
        rgba_d     = rgba_q;
        z_d        = z_q;
        zen_d      = zen_q;
        last_d     = last_q;
        off_d      = off_q;
        pair_d     = pair_q;
        byte_d     = byte_q;
        drop_d     = drop_q;
        frag_ready = 1'b0;
        FF_write   = 1'b0;
        FF_data    = 32'h0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d  = fb_width;
                    height_d = fb_height;
                    pair_d   = '0;
                    byte_d   = '0;
                    drop_d   = '0;
                    state_d  = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                frag_ready = 1'b1;
                if (frag_valid) begin
                    x_d     = frag_x;
                    y_d     = frag_y;
                    rgba_d  = frag_rgba;
                    z_d     = frag_z;
                    zen_d   = frag_z_en;
                    last_d  = frag_last;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!in_range) begin
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                    state_d = frag_end_state;
                end else begin
                    off_d   = off_calc;
                    state_d = S_PUSH_CADDR;
                end
            end
            S_PUSH_CADDR: begin
                FF_data = {7'b0, 1'b1, off_q};
                if (!FF_full) begin
                    FF_write = 1'b1;
                    state_d  = S_PUSH_CDATA;
                end
            end
            S_PUSH_CDATA: begin
                FF_data = rgba_q;
                if (!FF_full) begin
                    FF_write = 1'b1;
                    pair_d   = pair_q + 32'd1;
                    byte_d   = byte_q + 32'd4;
                    state_d  = zen_q ? S_PUSH_ZADDR : frag_end_state;
                end
            end
            S_PUSH_ZADDR: begin
                FF_data = {7'b0, 1'b0, zoff};
                if (!FF_full) begin
                    FF_write = 1'b1;
                    state_d  = S_PUSH_ZDATA;
                end
            end
            S_PUSH_ZDATA: begin
                FF_data = z_q;
                if (!FF_full) begin
                    FF_write = 1'b1;
                    pair_d   = pair_q + 32'd1;
                    byte_d   = byte_q + 32'd4;
                    state_d  = frag_end_state;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pair_count = pair_q;
    assign byte_count = byte_q;
    assign drop_count = drop_q;

endmodule
